div_iter: RTL and testbench

Iterative 32-bit MIPS divider for DIV/DIVU in the execute stage. Accepts operands when the E-stage start request is raised and computes one quotient bit per cycle with a radix-2 restoring algorithm. It returns {remainder, quotient} for the HI/LO write with a one-cycle `done` pulse. It produces the `divdoneE` signal the hazard unit combines with `divstartE` to stall F/D/E. While `start` is high and `done` is low, the pipeline holds E, so `start` stays asserted until `done`.

---
 rtl/div_if.sv | 23 ++
 rtl/div_iter.sv | 95 +++++++++
 tb/tb_div_iter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and data bundle between the E-stage control and the iterative divider.
interface div_if #(
  parameter int WIDTH = 32
) ();
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               annul;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  busy, done, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output busy, done, result
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} with a one-cycle done pulse.
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave dif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] result_q;

  logic               sa, sb, bz;
  logic [WIDTH-1:0]   bmag;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               accept;
  logic               sa_in, sb_in;
  logic [WIDTH:0]     rem_sh;
  logic signed [WIDTH:0] trial;
  logic               ge;
  logic [WIDTH-1:0]   q_fin, r_fin;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign accept = (state == IDLE) && dif.start && !dif.annul;
  assign sa_in  = dif.signed_div & dif.a[WIDTH-1];
  assign sb_in  = dif.signed_div & dif.b[WIDTH-1];

  // A carry out of the shifted remainder means it already exceeds any divisor.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = $signed(rem_sh) - $signed({1'b0, bmag});
  assign ge     = rem_sh[WIDTH] | ~trial[WIDTH];

  // Divide by zero leaves rem = |a|, so only the remainder sign fix is kept.
  assign q_fin = bz ? '1 : cond_neg(quo, sa ^ sb);
  assign r_fin = cond_neg(rem, sa);

  assign dif.busy   = (state == BUSY);
  assign dif.done   = (state == DONE) && !dif.annul;
  assign dif.result = dif.done ? {r_fin, q_fin} : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (dif.annul) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!dif.annul) result_q <= {r_fin, q_fin};
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and the per-cycle shift/subtract step.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa   <= sa_in;
      sb   <= sb_in;
      bz   <= (dif.b == '0);
      bmag <= cond_neg(dif.b, sb_in);
      rem  <= '0;
      quo  <= cond_neg(dif.a, sa_in);
    end else if (state == BUSY) begin
      rem <= ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ge};
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: latency, signed/unsigned results, divide by
// zero, annul, mid-operation reset and back-to-back operation.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) dif ();
  div_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .dif(dif));

  int          nvec = 0;
  int          nmis = 0;
  logic [63:0] sbq[$];
  logic [63:0] last_res = '0;

  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic s,
                        input bit push, input logic [63:0] exp);
    @(posedge clk); #1;
    dif.start      = 1'b1;
    dif.annul      = 1'b0;
    dif.a          = ta;
    dif.b          = tb_;
    dif.signed_div = s;
    if (push) sbq.push_back(exp);
  endtask

  // Watches from cycle 0 until done; operands are scrambled while BUSY.
  task automatic observe(input int maxc, input bit drop, output int dcyc,
                         output logic [63:0] res, output bit bok);
    dcyc = -1;
    res  = 'x;
    bok  = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (dif.busy !== ((c >= 1) && (c <= 32))) bok = 1'b0;
      if (dif.done === 1'b1) begin
        dcyc = c;
        res  = dif.result;
        break;
      end
      @(posedge clk); #1;
      if (c == 2) begin
        dif.a          = $urandom;
        dif.b          = $urandom;
        dif.signed_div = ~dif.signed_div;
      end
    end
    if (drop) begin
      @(posedge clk); #1;
      dif.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++; if (dif.busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b expected 0", dif.busy); end
    nvec++; if (dif.done !== 1'b0) begin nmis++; $display("FAIL reset_done: got %b expected 0", dif.done); end
    nvec++; if (dif.result !== 64'd0) begin nmis++; $display("FAIL reset_result: got %h expected 0", dif.result); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_divu();
    int dcyc; logic [63:0] res, exp; bit bok;
    launch(32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14});
    observe(40, 1'b1, dcyc, res, bok);
    exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
    nvec++; if (dcyc !== 33) begin nmis++; $display("FAIL divu_latency: got %0d expected 33", dcyc); end
    nvec++; if (res !== exp) begin nmis++; $display("FAIL divu_result: got %h expected %h", res, exp); end
    nvec++; if (bok !== 1'b1) begin nmis++; $display("FAIL divu_busy_window: got %b expected 1", bok); end
    @(negedge clk);
    nvec++; if (dif.done !== 1'b0) begin nmis++; $display("FAIL divu_done_pulse: got %b expected 0", dif.done); end
    nvec++; if (dif.result !== exp) begin nmis++; $display("FAIL divu_result_hold: got %h expected %h", dif.result, exp); end
    last_res = exp;
  endtask

  task automatic test_signed();
    logic [31:0] ta [6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF8};
    logic [31:0] tbv[6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic        sg [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] ex [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0000_0001, 32'hFFFF_FFFD},
                            {32'h0, 32'h8000_0000}, {32'h8000_0000, 32'h0},
                            {32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFF8, 32'hFFFF_FFFF}};
    for (int i = 0; i < 6; i++) begin
      int dcyc; logic [63:0] res, exp; bit bok;
      launch(ta[i], tbv[i], sg[i], 1'b1, ex[i]);
      observe(40, 1'b1, dcyc, res, bok);
      exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
      nvec++; if (dcyc !== 33) begin nmis++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, dcyc); end
      nvec++; if (res !== exp) begin nmis++; $display("FAIL signed_result[%0d]: got %h expected %h", i, res, exp); end
      last_res = exp;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int dcyc; logic [63:0] res, exp; bit bok;
      logic [31:0] ta, tb_;
      logic signed [31:0] sa_v, sb_v;
      logic s;
      s   = i[0];
      ta  = $urandom;
      tb_ = (i < 4) ? $urandom : $urandom_range(1, 1000);
      if (s && (i % 4 == 3)) tb_ = -tb_;
      if (tb_ == 0) tb_ = 32'd1;
      if (s && ta == 32'h8000_0000 && tb_ == 32'hFFFF_FFFF) tb_ = 32'd3;
      sa_v = ta;
      sb_v = tb_;
      if (s) exp = {32'(sa_v % sb_v), 32'(sa_v / sb_v)};
      else   exp = {ta % tb_, ta / tb_};
      launch(ta, tb_, s, 1'b1, exp);
      observe(40, 1'b1, dcyc, res, bok);
      exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
      nvec++; if (res !== exp) begin nmis++; $display("FAIL random_result[%0d]: got %h expected %h", i, res, exp); end
      last_res = exp;
    end
  endtask

  task automatic test_annul();
    int dcyc; logic [63:0] res, exp; bit bok;
    launch(32'd100, 32'd7, 1'b0, 1'b0, '0);
    repeat (10) begin @(posedge clk); #1; end
    dif.annul = 1'b1;
    @(negedge clk);
    nvec++; if (dif.done !== 1'b0) begin nmis++; $display("FAIL annul_done: got %b expected 0", dif.done); end
    nvec++; if (dif.result !== last_res) begin nmis++; $display("FAIL annul_result: got %h expected %h", dif.result, last_res); end
    launch(32'd9, 32'd3, 1'b0, 1'b1, {32'd0, 32'd3});
    observe(40, 1'b1, dcyc, res, bok);
    exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
    nvec++; if (dcyc !== 33) begin nmis++; $display("FAIL annul_restart_latency: got %0d expected 33", dcyc); end
    nvec++; if (res !== exp) begin nmis++; $display("FAIL annul_restart_result: got %h expected %h", res, exp); end
    last_res = exp;
    // annul landing on the DONE cycle must suppress both done and the load
    launch(32'd20, 32'd3, 1'b0, 1'b0, '0);
    repeat (33) begin @(posedge clk); #1; end
    dif.annul = 1'b1;
    @(negedge clk);
    nvec++; if (dif.done !== 1'b0) begin nmis++; $display("FAIL annul_done_state: got %b expected 0", dif.done); end
    @(posedge clk); #1;
    dif.annul = 1'b0;
    dif.start = 1'b0;
    @(negedge clk);
    nvec++; if (dif.result !== last_res) begin nmis++; $display("FAIL annul_done_hold: got %h expected %h", dif.result, last_res); end
  endtask

  task automatic test_rst_mid();
    bit seen;
    launch(32'd100, 32'd7, 1'b0, 1'b0, '0);
    repeat (10) begin @(posedge clk); #1; end
    rst       = 1'b1;
    dif.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (dif.busy !== 1'b0) begin nmis++; $display("FAIL rst_mid_busy: got %b expected 0", dif.busy); end
    nvec++; if (dif.result !== 64'd0) begin nmis++; $display("FAIL rst_mid_result: got %h expected 0", dif.result); end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (dif.done !== 1'b0) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nmis++; $display("FAIL rst_mid_no_done: got %b expected 0", seen); end
    last_res = '0;
  endtask

  task automatic test_back_to_back();
    int dcyc; logic [63:0] res, exp; bit bok;
    launch(32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14});
    observe(40, 1'b0, dcyc, res, bok);
    exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
    nvec++; if (dcyc !== 33) begin nmis++; $display("FAIL b2b_first_latency: got %0d expected 33", dcyc); end
    nvec++; if (res !== exp) begin nmis++; $display("FAIL b2b_first_result: got %h expected %h", res, exp); end
    launch(32'd50, 32'd8, 1'b0, 1'b1, {32'd2, 32'd6});
    observe(40, 1'b1, dcyc, res, bok);
    exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
    nvec++; if (dcyc !== 33) begin nmis++; $display("FAIL b2b_second_latency: got %0d expected 33", dcyc); end
    nvec++; if (res !== exp) begin nmis++; $display("FAIL b2b_second_result: got %h expected %h", res, exp); end
    nvec++; if (bok !== 1'b1) begin nmis++; $display("FAIL b2b_busy_window: got %b expected 1", bok); end
  endtask

  initial begin
    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.annul      = 1'b0;
    dif.signed_div = 1'b0;
    dif.a          = '0;
    dif.b          = '0;
    test_reset();
    test_divu();
    test_signed();
    test_random();
    test_annul();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
